// File: rtl/lc3b_fetch_pkg.sv
// Shared types and constants for the LC-3b instruction-fetch sequencer.
package lc3b_fetch_pkg;

    localparam int unsigned PC_WIDTH    = 16;
    localparam int unsigned INSTR_BYTES = 2;
    localparam int unsigned CNT_WIDTH   = 8;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_HOLD,
        ST_DRAIN,
        ST_FAULT
    } fetch_state_e;

endpackage

// File: rtl/lc3b_fetch_ctrl.sv
// LC-3b fetch sequencer: drives the PC register, fetches over a ready handshake,
// hands instructions to decode and applies control-flow redirects.
module lc3b_fetch_ctrl
    import lc3b_fetch_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 16'h0000,
    parameter int unsigned         MEM_TIMEOUT  = 15
) (
    input  logic                clock_50,
    input  logic                reset_n,
    input  logic [PC_WIDTH-1:0] pc_q,
    output logic                pc_load,
    output logic [PC_WIDTH-1:0] pc_next,
    output logic                mem_req,
    output logic [PC_WIDTH-1:0] mem_addr,
    input  logic                mem_ready,
    input  logic [PC_WIDTH-1:0] mem_rdata,
    output logic                ir_valid,
    output logic [PC_WIDTH-1:0] ir_data,
    output logic [PC_WIDTH-1:0] ir_pc_plus2,
    input  logic                ir_ready,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_addr,
    output logic                fetch_fault
);

    fetch_state_e          state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [PC_WIDTH-1:0]   ir_data_q, ir_data_d;
    logic [PC_WIDTH-1:0]   ir_pc_plus2_q, ir_pc_plus2_d;
    logic [PC_WIDTH-1:0]   drain_addr_q, drain_addr_d;

    logic [PC_WIDTH-1:0]   pc_plus2;
    logic [PC_WIDTH-1:0]   redirect_tgt;
    logic                  timeout;
    logic                  unused_redirect_lsb;

    assign pc_plus2            = pc_q + PC_WIDTH'(INSTR_BYTES);
    assign redirect_tgt        = {redirect_addr[PC_WIDTH-1:1], 1'b0};
    assign timeout             = (cnt_q == MEM_TIMEOUT[CNT_WIDTH-1:0]);
    assign unused_redirect_lsb = redirect_addr[0];

    assign ir_data     = ir_data_q;
    assign ir_pc_plus2 = ir_pc_plus2_q;

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_INIT;
            cnt_q         <= '0;
            ir_data_q     <= '0;
            ir_pc_plus2_q <= '0;
            drain_addr_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ir_data_q     <= ir_data_d;
            ir_pc_plus2_q <= ir_pc_plus2_d;
            drain_addr_q  <= drain_addr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ir_data_d     = ir_data_q;
        ir_pc_plus2_d = ir_pc_plus2_q;
        drain_addr_d  = drain_addr_q;
        pc_load       = 1'b0;
        pc_next       = pc_plus2;
        mem_req       = 1'b0;
        mem_addr      = pc_q;
        ir_valid      = 1'b0;
        fetch_fault   = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                pc_load = 1'b1;
                pc_next = RESET_VECTOR;
                cnt_d   = '0;
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    cnt_d   = '0;
                    pc_load = 1'b1;
                    if (redirect_valid) begin
                        pc_next = redirect_tgt;
                    end else begin
                        ir_data_d     = mem_rdata;
                        ir_pc_plus2_d = pc_plus2;
                        state_d       = ST_HOLD;
                    end
                end else if (timeout) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (redirect_valid) begin
                        // The read is still in flight: remember its address for the drain.
                        pc_load      = 1'b1;
                        pc_next      = redirect_tgt;
                        drain_addr_d = pc_q;
                        state_d      = ST_DRAIN;
                    end
                end
            end

            ST_HOLD: begin
                ir_valid = !redirect_valid;
                cnt_d    = '0;
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    pc_next = redirect_tgt;
                    state_d = ST_FETCH;
                end else if (ir_ready) begin
                    state_d = ST_FETCH;
                end
            end

            ST_DRAIN: begin
                mem_req  = 1'b1;
                mem_addr = drain_addr_q;
                if (mem_ready) begin
                    cnt_d   = '0;
                    state_d = ST_FETCH;
                end else if (timeout) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (redirect_valid && (mem_ready || !timeout)) begin
                    pc_load = 1'b1;
                    pc_next = redirect_tgt;
                end
            end

            ST_FAULT: begin
                fetch_fault = 1'b1;
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

endmodule
